joypad_snes_multi_adapter: RTL and testbench
============================================

JOYPAD_SNES_MULTI_ADAPTER -- requirements
Module: joypad_snes_multi_adapter

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2, number of SNES pads on shared latch/clock (legal 1..4).
REQ-002 SHALL have parameter NUM_BITS, default 16, serial bits shifted per pad per frame (legal 12..16).
REQ-003 SHALL have parameter CLK_DIV, default 2048, clock cycles per protocol tick (legal >=2).
REQ-004 SHALL have parameter POLL_TICKS, default 32, idle ticks between frames (legal >=1).
REQ-005 SHALL have ports: clock  in  1  single system clock, all logic on posedge; one clock, reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 button_sel  in  2  Game Boy P14/P15 select, active-low.
REQ-008 pad_sel  in  2  index of pad presented to Game Boy.
REQ-009 button_data  out  4  Game Boy P10-P13, active-low.
REQ-010 controller_data  in  NUM_PADS  serial data per pad, active-low (0 = pressed).
REQ-011 controller_latch  out  1  shared latch, active-high.
REQ-012 controller_clock  out  1  shared shift clock, idles high.
REQ-013 button_state  out  16*NUM_PADS  committed snapshot, pad p at [16p+15:16p], active-low.
REQ-014 frame_done  out  1  one-cycle pulse on snapshot commit.
REQ-015 joypad_irq  out  1  one-cycle pulse, see Configuration.

Function
REQ-016 Tick: divider counts 0..CLK_DIV-1, wraps; tick asserted for one clock when count = CLK_DIV-1; FSM advances only on tick.
REQ-017 States IDLE -> LATCH -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | DONE) -> IDLE.
REQ-018 IDLE: hold POLL_TICKS ticks, then LATCH.
REQ-019 LATCH: controller_latch = 1 for exactly 2 ticks (2*CLK_DIV clocks), then SHIFT_LO with bit index 0.
REQ-020 SHIFT_LO: controller_clock = 0 for 1 tick; on entry tick, controller_data[p] sampled into shadow bit [index] of every pad simultaneously.
REQ-021 SHIFT_HI: controller_clock = 1 for 1 tick; at end index increments; if index was NUM_BITS-1 go DONE, else SHIFT_LO.
REQ-022 DONE: one clock (not tick-gated); shadow bits >= NUM_BITS forced 1; shadow copied to button_state for all pads in same clock; frame_done = 1 that clock; then IDLE.
REQ-023 Frame period = (POLL_TICKS + 2 + 2*NUM_BITS)*CLK_DIV + 1 clocks, constant.
REQ-024 controller_latch, controller_clock, frame_done SHALL be registered (glitch-free); controller_clock = 1 in all states except SHIFT_LO.
REQ-025 Bit order per pad: 0 B,1 Y,2 Select,3 Start,4 Up,5 Down,6 Left,7 Right,8 A,9 X,10 L,11 R.
REQ-026 Direction group D = {Down,Up,Left,Right} as button_data[3:0]; action group A = {Start,Select,B,A} as button_data[3:0], taken from pad pad_sel.
REQ-027 button_data combinational: sel=2'b10 -> D; 2'b01 -> A; 2'b00 -> D & A (bitwise); 2'b11 -> 4'b1111.
REQ-028 pad_sel >= NUM_PADS -> button_data = 4'b1111.
REQ-029 button_state changes only in DONE; Game Boy never sees a partial frame.

Reset
REQ-030 Reset SHALL force: FSM IDLE, divider 0, idle count 0, bit index 0, shadow and button_state all-ones, controller_latch 0, controller_clock 1, frame_done 0, joypad_irq 0, IRQ history all-ones.
REQ-031 Reset mid-frame SHALL abandon the frame without commit; first latch follows POLL_TICKS full ticks after reset release.

Configuration
REQ-032 Macro JOYPAD_IRQ_EN defined: joypad_irq pulses one clock after any button_data bit goes 1->0 versus previous clock's registered value (covers select, pad_sel and snapshot changes).
REQ-033 Macro JOYPAD_IRQ_EN undefined: joypad_irq tied 0, no history register; port still present.

Verification
REQ-034 NUM_PADS=2, CLK_DIV=4, POLL_TICKS=2, reset released -> latch rises at clock 8 after release, high exactly 8 clocks, then 16 clock-low pulses of 4 clocks each.
REQ-035 Pad0 model drives 16'hFEFF (A pressed), pad1 16'hFFEF (Up); pad_sel=0, sel=2'b01 -> button_data 4'b1110 after frame_done; pad_sel=1, sel=2'b10 -> 4'b1011.
REQ-036 sel=2'b00, pad0 with Right and B pressed -> button_data 4'b1100; sel=2'b11 -> 4'b1111; pad_sel=3 with NUM_PADS=2 -> 4'b1111.
REQ-037 NUM_BITS=12, pads drive all-zero -> button_state[15:12] of each pad = 4'hF, [11:0] = 12'h000.
REQ-038 Reset asserted during SHIFT_LO of bit 5 -> next clock latch 0, clock 1, button_state 16'hFFFF, no frame_done.
REQ-039 JOYPAD_IRQ_EN defined, sel=2'b01, A pressed in new frame -> joypad_irq high exactly one clock after frame_done; release -> no pulse; undefined -> joypad_irq stays 0.

Source files
------------

// File: rtl/joypad_snes_multi_adapter.sv
// Polls up to four SNES pads on a shared latch/clock and presents one pad to a Game Boy matrix.
// Optional JOYPAD_IRQ_EN macro enables a falling-edge interrupt on button_data.
module joypad_snes_multi_adapter #(
  parameter int unsigned NUM_PADS   = 2,
  parameter int unsigned NUM_BITS   = 16,
  parameter int unsigned CLK_DIV    = 2048,
  parameter int unsigned POLL_TICKS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               button_sel,
  input  logic [1:0]               pad_sel,
  output logic [3:0]               button_data,
  input  logic [NUM_PADS-1:0]      controller_data,
  output logic                     controller_latch,
  output logic                     controller_clock,
  output logic [16*NUM_PADS-1:0]   button_state,
  output logic                     frame_done,
  output logic                     joypad_irq
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(POLL_TICKS + 2);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(POLL_TICKS - 1);
  localparam logic [CNT_W-1:0] LATCH_MAX = CNT_W'(1);
  localparam logic [3:0]       BIT_MAX  = 4'(NUM_BITS - 1);
  // Bits the pads never shift in read back as released.
  localparam logic [15:0]      PAD_MASK = ~16'((32'd1 << NUM_BITS) - 32'd1);

  typedef enum logic [2:0] {StIdle, StLatch, StShiftLo, StShiftHi, StDone} state_e;

  state_e                      r_state, w_state_next;
  logic [DIV_W-1:0]            r_div;
  logic [CNT_W-1:0]            r_cnt, w_cnt_next;
  logic [3:0]                  r_idx, w_idx_next;
  logic                        w_tick, w_sample;
  logic [NUM_PADS-1:0][15:0]   r_shadow, r_buttons;
  logic                        r_latch, r_clk, r_done;
  logic [15:0]                 w_pad;
  logic [3:0]                  w_dir, w_act;

  assign w_tick = (r_div == DIV_MAX);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_sample     = 1'b0;
    unique case (r_state)
      StIdle: if (w_tick) begin
        if (r_cnt == IDLE_MAX) begin
          w_state_next = StLatch;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StLatch: if (w_tick) begin
        if (r_cnt == LATCH_MAX) begin
          w_state_next = StShiftLo;
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_sample     = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StShiftLo: if (w_tick) w_state_next = StShiftHi;
      StShiftHi: if (w_tick) begin
        if (r_idx == BIT_MAX) begin
          w_state_next = StDone;
          w_idx_next   = '0;
        end else begin
          w_state_next = StShiftLo;
          w_idx_next   = r_idx + 1'b1;
          w_sample     = 1'b1;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // The divider parks during the single DONE clock so every frame has the same length.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_latch <= 1'b0;
      r_clk   <= 1'b1;
      r_done  <= 1'b0;
      r_shadow  <= '1;
      r_buttons <= '1;
    end else begin
      r_state <= w_state_next;
      if (r_state != StDone) r_div <= w_tick ? '0 : r_div + 1'b1;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_latch <= (w_state_next == StLatch);
      r_clk   <= (w_state_next != StShiftLo);
      r_done  <= (w_state_next == StDone);
      for (int p = 0; p < NUM_PADS; p++) begin
        if (w_sample) r_shadow[p][w_idx_next] <= controller_data[p];
        if (w_state_next == StDone) r_buttons[p] <= r_shadow[p] | PAD_MASK;
      end
    end
  end

  assign controller_latch = r_latch;
  assign controller_clock = r_clk;
  assign frame_done       = r_done;
  assign button_state     = r_buttons;

  always_comb begin
    w_pad = 16'hFFFF;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (pad_sel == 2'(p)) w_pad = r_buttons[p];
    end
    w_dir = {w_pad[5], w_pad[4], w_pad[6], w_pad[7]};
    w_act = {w_pad[3], w_pad[2], w_pad[0], w_pad[8]};
    unique case (button_sel)
      2'b10:   button_data = w_dir;
      2'b01:   button_data = w_act;
      2'b00:   button_data = w_dir & w_act;
      default: button_data = 4'b1111;
    endcase
  end

`ifdef JOYPAD_IRQ_EN
  logic [3:0] r_hist;
  logic       r_irq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist <= 4'b1111;
      r_irq  <= 1'b0;
    end else begin
      r_hist <= button_data;
      r_irq  <= |(r_hist & ~button_data);
    end
  end

  assign joypad_irq = r_irq;
`else
  assign joypad_irq = 1'b0;
`endif

endmodule

// File: tb/tb_joypad_snes_multi_adapter.sv
// Self-checking bench: SNES pad models, vector table, random frames against a button model.
module tb_joypad_snes_multi_adapter;

  localparam int unsigned NP = 2, NB = 16, CD = 4, PT = 2;
  localparam int unsigned FRAME   = (PT + 2 + 2 * NB) * CD + 1;
  localparam int unsigned FRAME12 = (1 + 2 + 2 * 12) * CD + 1;
`ifdef JOYPAD_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif
  // Bit positions of each group, listed from button_data[0] upward.
  localparam int DIR_POS [4] = '{7, 6, 4, 5};
  localparam int ACT_POS [4] = '{8, 0, 2, 3};

  logic              clock = 1'b0, reset = 1'b1;
  logic [1:0]        button_sel = 2'b01, pad_sel = 2'd0;
  logic [3:0]        button_data;
  logic [NP-1:0]     controller_data;
  logic              controller_latch, controller_clock, frame_done, joypad_irq;
  logic [16*NP-1:0]  button_state;

  logic [3:0]        bd12;
  logic              latch12, clk12, fd12, irq12;
  logic [15:0]       bs12;

  int n_tests = 0, n_fail = 0;
  int cycle = 0;
  logic [15:0] pad_word [NP];

  joypad_snes_multi_adapter #(
    .NUM_PADS(NP), .NUM_BITS(NB), .CLK_DIV(CD), .POLL_TICKS(PT)
  ) u_dut (
    .clock(clock), .reset(reset), .button_sel(button_sel), .pad_sel(pad_sel),
    .button_data(button_data), .controller_data(controller_data),
    .controller_latch(controller_latch), .controller_clock(controller_clock),
    .button_state(button_state), .frame_done(frame_done), .joypad_irq(joypad_irq)
  );

  joypad_snes_multi_adapter #(
    .NUM_PADS(1), .NUM_BITS(12), .CLK_DIV(CD), .POLL_TICKS(1)
  ) u_dut12 (
    .clock(clock), .reset(reset), .button_sel(2'b00), .pad_sel(2'd0),
    .button_data(bd12), .controller_data(1'b0),
    .controller_latch(latch12), .controller_clock(clk12),
    .button_state(bs12), .frame_done(fd12), .joypad_irq(irq12)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  // Pad: reloads on latch, advances one bit per rising shift clock.
  for (genvar p = 0; p < NP; p++) begin : g_pad
    int ptr = 0;
    always @(posedge controller_clock or posedge controller_latch) begin
      if (controller_latch) ptr <= 0;
      else ptr <= ptr + 1;
    end
    assign controller_data[p] = (ptr < 16) ? pad_word[p][ptr[3:0]] : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] gb_model(input logic [31:0] st, input logic [1:0] sel,
                                          input logic [1:0] ps);
    logic [3:0] d, a, res;
    if (int'(ps) >= NP) return 4'b1111;
    for (int k = 0; k < 4; k++) begin
      d[k] = st[16 * int'(ps) + DIR_POS[k]];
      a[k] = st[16 * int'(ps) + ACT_POS[k]];
    end
    res = 4'b1111;
    if (!sel[0]) res = res & d;
    if (!sel[1]) res = res & a;
    return res;
  endfunction

  // Returns at the negedge inside the commit clock.
  task automatic wait_frame();
    logic [16*NP-1:0] prev;
    bit stable, seen;
    prev = button_state;
    stable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clock);
      if (frame_done) seen = 1'b1;
      else if (button_state !== prev) stable = 1'b0;
    end
    check("frame_done seen", 64'(seen), 64'd1);
    check("state stable mid-frame", 64'(stable), 64'd1);
  endtask

  typedef struct {
    logic [15:0] w0, w1;
    logic [1:0]  sel, ps;
    logic [3:0]  exp;
  } vec_t;
  vec_t vecs [7];

  initial begin
    int k, bad, t_rise, falls;
    bit prev_clk, seen;
    logic [1:0] rs, rp;
    logic [15:0] r0, r1;

    vecs[0] = '{16'hFEFF, 16'hFFEF, 2'b01, 2'd0, 4'b1110};
    vecs[1] = '{16'hFEFF, 16'hFFEF, 2'b10, 2'd1, 4'b1011};
    vecs[2] = '{16'hFF7E, 16'hFFFF, 2'b00, 2'd0, 4'b1100};
    vecs[3] = '{16'hFF7E, 16'hFFFF, 2'b11, 2'd0, 4'b1111};
    vecs[4] = '{16'hFEFF, 16'hFFEF, 2'b01, 2'd3, 4'b1111};
    vecs[5] = '{16'h0000, 16'h0000, 2'b10, 2'd1, 4'b0000};
    vecs[6] = '{16'hFFFF, 16'hFFF0, 2'b01, 2'd1, 4'b0001};
    pad_word[0] = 16'hFFFF;
    pad_word[1] = 16'hFFFF;

    repeat (3) @(negedge clock);
    check("reset latch", 64'(controller_latch), 64'd0);
    check("reset clock", 64'(controller_clock), 64'd1);
    check("reset state", 64'(button_state), 64'hFFFF_FFFF);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset irq", 64'(joypad_irq), 64'd0);
    check("reset button_data", 64'(button_data), 64'hF);
    reset = 1'b0;

    k = 0;
    do begin @(posedge clock); #1; k++; end while (!controller_latch && k < 100);
    check("latch rise delay", 64'(k), 64'd8);
    t_rise = cycle;
    k = 0;
    do begin @(posedge clock); #1; k++; end while (controller_latch && k < 100);
    check("latch width", 64'(k), 64'd8);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      k = 0;
      do begin @(posedge clock); #1; k++; end while (!controller_clock && k < 100);
      if (k != 4) bad++;
      if (i < 15) begin
        k = 0;
        do begin @(posedge clock); #1; k++; end while (controller_clock && k < 100);
        if (k != 4) bad++;
      end
    end
    check("shift pulse widths", 64'(bad), 64'd0);
    k = 0;
    do begin @(posedge clock); #1; k++; end while (!controller_latch && k < 400);
    check("frame period", 64'(cycle - t_rise), 64'(FRAME));

    wait_frame();
    foreach (vecs[i]) begin
      pad_word[0] = vecs[i].w0;
      pad_word[1] = vecs[i].w1;
      wait_frame();
      check("vec button_state", 64'(button_state), 64'({vecs[i].w1, vecs[i].w0}));
      button_sel = vecs[i].sel;
      pad_sel = vecs[i].ps;
      #1;
      check("vec button_data", 64'(button_data), 64'(vecs[i].exp));
    end

    for (int r = 0; r < 16; r++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      pad_word[0] = r0;
      pad_word[1] = r1;
      wait_frame();
      check("rand button_state", 64'(button_state), 64'({r1, r0}));
      for (int j = 0; j < 3; j++) begin
        rs = 2'($urandom);
        rp = 2'($urandom);
        button_sel = rs;
        pad_sel = rp;
        #1;
        check("rand button_data", 64'(button_data), 64'(gb_model({r1, r0}, rs, rp)));
      end
    end

    button_sel = 2'b01;
    pad_sel = 2'd0;
    pad_word[0] = 16'hFFFF;
    pad_word[1] = 16'hFFFF;
    wait_frame();
    pad_word[0] = 16'hFEFF;
    wait_frame();
    check("irq at commit", 64'(joypad_irq), 64'd0);
    @(negedge clock);
    check("irq after press", 64'(joypad_irq), 64'(IRQ_EXP));
    @(negedge clock);
    check("irq one clock", 64'(joypad_irq), 64'd0);
    pad_word[0] = 16'hFFFF;
    wait_frame();
    check("irq release commit", 64'(joypad_irq), 64'd0);
    @(negedge clock);
    check("irq release +1", 64'(joypad_irq), 64'd0);
    @(negedge clock);
    check("irq release +2", 64'(joypad_irq), 64'd0);

    pad_word[0] = 16'h0000;
    pad_word[1] = 16'h0000;
    wait_frame();
    check("zero frame state", 64'(button_state), 64'd0);
    falls = 0;
    prev_clk = controller_clock;
    for (int i = 0; i < 2 * FRAME && falls < 6; i++) begin
      @(negedge clock);
      if (prev_clk && !controller_clock) falls++;
      prev_clk = controller_clock;
    end
    check("reached bit5 shift", 64'(falls), 64'd6);
    reset = 1'b1;
    @(negedge clock);
    check("midreset latch", 64'(controller_latch), 64'd0);
    check("midreset clock", 64'(controller_clock), 64'd1);
    check("midreset state", 64'(button_state), 64'hFFFF_FFFF);
    check("midreset frame_done", 64'(frame_done), 64'd0);
    reset = 1'b0;
    k = 0;
    seen = 1'b0;
    do begin
      @(posedge clock); #1; k++;
      if (frame_done) seen = 1'b1;
    end while (!controller_latch && k < 100);
    check("latch after midreset", 64'(k), 64'd8);
    check("no commit after midreset", 64'(seen), 64'd0);

    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME12 && !seen; i++) begin
      @(negedge clock);
      if (fd12) seen = 1'b1;
    end
    check("nb12 frame_done", 64'(seen), 64'd1);
    check("nb12 upper forced", 64'(bs12[15:12]), 64'hF);
    check("nb12 lower bits", 64'(bs12[11:0]), 64'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
